hier_node_agg: RTL and testbench
================================

Name: hier_node_agg

Overview:
- Parametrised hierarchy node for the generated module trees.
- Replaces fixed five-child structural nodes with a NUM_CHILDREN-wide node, built from a generate loop of per-child slot instances.
- Adds real traffic aggregation: each child presents a valid/ready data channel. The node buffers one word per child, arbitrates round-robin and forwards words upstream through a registered output stage.
- Nodes chain: the up port of one node connects to a child port of its parent.

Parameters:
- NUM_CHILDREN, 5, number of child channels (1..16).
- DATA_W, 16, payload width per channel.
- ID_W, $clog2(NUM_CHILDREN) (min 1), width of the source index; derived, not overridden.
- CNT_W, 8, width of the per-child saturating forward counters.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- child_valid  in  NUM_CHILDREN  per-child word valid.
- child_ready  out  NUM_CHILDREN  per-child slot can accept.
- child_data  in  NUM_CHILDREN*DATA_W  packed payloads; child i occupies bits [i*DATA_W +: DATA_W].
- up_valid  out  1  output register holds a word.
- up_ready  in  1  parent accepts.
- up_data  out  DATA_W  forwarded payload.
- up_id  out  ID_W  index of the source child.
- fwd_cnt  out  NUM_CHILDREN*CNT_W  per-child count of words forwarded upstream, saturating.
- busy  out  1  high if any slot is full or up_valid is high.

Behaviour:
- Reset: synchronous on a rising clk edge with rst_n=0.
  - All slots are emptied; up_valid=0, up_data=0, up_id=0, fwd_cnt=0.
  - Round-robin pointer is set to 0, busy=0; child_ready reads 0 while rst_n=0.
  - A reset mid-transfer drops buffered words silently.
- Slot (one per child), single entry:
  - child_ready[i] = !full[i] || (grant[i] && load), where load is defined under Output stage.
  - Accept on child_valid[i] && child_ready[i]: full[i] is set and the data is captured at the edge.
  - Simultaneous drain and accept in the same cycle leaves full[i]=1 holding the new data.
- Arbitration:
  - req = full.
  - load = |req && (!up_valid || up_ready).
  - Grant goes to the first requesting index at or after ptr, cyclically; wrap NUM_CHILDREN-1 -> 0.
  - On load, ptr <= granted index + 1, mod NUM_CHILDREN.
  - When !load, no grant is issued and ptr holds.
- Output stage:
  - On load: up_data <= slot data, up_id <= grant index, up_valid <= 1, and the granted slot is cleared (unless refilled in the same cycle, as above).
  - When up_valid && up_ready && !load, up_valid <= 0.
  - While up_valid && !up_ready, up_data and up_id are stable.
- Throughput and latency:
  - One word per cycle sustained when up_ready=1.
  - Latency is 2 cycles: a word accepted at edge t is in its slot after t and appears on up_* after edge t+1.
- Forward counters:
  - fwd_cnt[i] increments on the cycle a word from child i fires upstream (up_valid && up_ready && up_id==i).
  - Saturates at 2^CNT_W-1, no wrap.
- busy = |full || up_valid (combinational from registers).
- Degenerate NUM_CHILDREN=1: ptr is constant 0 and up_id=0. The node is a 2-deep pipeline.
- No ordering guarantee across children; per-child order is preserved.

Decomposition:
- Shared package hier_pkg, containing:
  - clog2-safe ID-width function.
  - MAX_CHILDREN=16 constant.
  - A packed struct for {data, id} used on up ports.
- One sub-module, hier_node_slot: single-entry buffer with valid/ready, instantiated NUM_CHILDREN times via generate.
- The arbiter and the output register stay inline in the node.

Test Plan:
- Reset: drive rst_n=0 for 3 cycles with child_valid all 1 -> child_ready=0, up_valid=0, fwd_cnt all 0, busy=0. After release, up_valid=1 two edges later.
- Single child: child 3 sends 0x00A5 with up_ready=1 -> up_valid rises 2 cycles later with up_data=0x00A5, up_id=3; fwd_cnt[3]=1 one cycle later; busy falls afterwards.
- Fairness: all 5 children hold valid continuously with up_ready=1 -> up_id sequence is 0,1,2,3,4,0,1... and each fwd_cnt advances by 1 every 5 cycles.
- Backpressure: up_ready=0 for 10 cycles with children 1 and 4 valid -> up_data/up_id are stable; child_ready[1] and child_ready[4] fall after one accept each. Releasing up_ready drains ids 1,4 in order with no loss or duplication.
- Wrap and pointer: ptr=4 with only children 0 and 4 requesting -> grants 4 then 0 and ptr returns to 1; same-cycle drain and refill on child 0 yields back-to-back words with no bubble.
- Saturation and reset mid-operation: CNT_W=2, child 2 forwards 5 words -> fwd_cnt[2]=3. Assert rst_n=0 while slots are full -> all slots are empty, up_valid=0, and no stale word appears after release.

Source files
------------

// File: rtl/hier_pkg.sv
// Shared definitions for the hierarchy-node family.
// Contents:
//   MAX_CHILDREN - largest supported child count per node
//   MAX_DATA_W   - widest payload the up-port word can carry
//   MAX_ID_W     - source-index width needed at MAX_CHILDREN
//   up_word_t    - {data, id} word presented on a node's up port
//   id_width()   - source-index width for a given child count, never below 1
package hier_pkg;

    localparam int MAX_CHILDREN = 16;
    localparam int MAX_DATA_W   = 64;
    localparam int MAX_ID_W     = $clog2(MAX_CHILDREN);

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_ID_W-1:0]   id;
    } up_word_t;

    // A single-child node still needs a 1-bit id so the port is never zero width.
    function automatic int id_width(input int n);
        int w;
        if (n <= 2) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/hier_node_slot.sv
// Single-entry buffer sitting between one child channel and the node arbiter.
// Ports:
//   clk_i, rst_ni      - clock, synchronous active-low reset
//   in_valid_i/_ready_o/_data_i - child-facing valid/ready channel
//   drain_i            - arbiter takes the held word this cycle
//   full_o, data_o     - occupancy and held word toward the arbiter
module hier_node_slot
    import hier_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              drain_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept_s;

    // Draining frees the entry in the same cycle, so a refill can land on the same edge.
    assign in_ready_o = rst_ni && (!full_q || drain_i);
    assign accept_s   = in_valid_i && in_ready_o;
    assign full_o     = full_q;
    assign data_o     = data_q;

    // Next-state: an accept wins over a drain, leaving the slot full with the new word.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (accept_s) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Slot state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/hier_node_agg.sv
// Parametrised hierarchy node: NUM_CHILDREN buffered child channels merged
// round-robin into one registered up port, with per-child forward counters.
// Ports:
//   clk_i, rst_ni                      - clock, synchronous active-low reset
//   child_valid_i/_ready_o/_data_i     - per-child channels, child i at [i*DATA_W +: DATA_W]
//   up_valid_o/up_ready_i/up_data_o/up_id_o - upstream channel with source index
//   fwd_cnt_o                          - saturating per-child count of words sent up
//   busy_o                             - any slot full or output register occupied
// DATA_W is limited to MAX_DATA_W and NUM_CHILDREN to 1..MAX_CHILDREN.
module hier_node_agg
    import hier_pkg::*;
#(
    parameter int  NUM_CHILDREN = 5,
    parameter int  DATA_W       = 16,
    parameter int  CNT_W        = 8,
    localparam int ID_W         = id_width(NUM_CHILDREN)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_CHILDREN-1:0]        child_valid_i,
    output logic [NUM_CHILDREN-1:0]        child_ready_o,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_data_i,
    output logic                           up_valid_o,
    input  logic                           up_ready_i,
    output logic [DATA_W-1:0]              up_data_o,
    output logic [ID_W-1:0]                up_id_o,
    output logic [NUM_CHILDREN*CNT_W-1:0]  fwd_cnt_o,
    output logic                           busy_o
);

    logic [NUM_CHILDREN-1:0] full_s;
    logic [NUM_CHILDREN-1:0] grant_s;
    logic [DATA_W-1:0]       slot_data_s [NUM_CHILDREN];
    logic [DATA_W-1:0]       sel_data_s;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         gidx_s;
    logic                    found_s;
    logic                    load_s;
    logic                    fire_s;
    up_word_t                up_q, up_d;
    logic                    up_valid_q, up_valid_d;
    logic [CNT_W-1:0]        cnt_q [NUM_CHILDREN];
    logic [CNT_W-1:0]        cnt_d [NUM_CHILDREN];

    for (genvar g = 0; g < NUM_CHILDREN; g++) begin : g_slot
        hier_node_slot #(.DATA_W(DATA_W)) u_slot (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .in_valid_i (child_valid_i[g]),
            .in_ready_o (child_ready_o[g]),
            .in_data_i  (child_data_i[g*DATA_W +: DATA_W]),
            .drain_i    (grant_s[g]),
            .full_o     (full_s[g]),
            .data_o     (slot_data_s[g])
        );
        assign fwd_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    // Padding bits of the shared up word are always zero; fold them into a sink.
    if (DATA_W < MAX_DATA_W) begin : g_data_pad
        logic unused_data_pad_s;
        assign unused_data_pad_s = ^up_q.data[MAX_DATA_W-1:DATA_W];
    end
    if (ID_W < MAX_ID_W) begin : g_id_pad
        logic unused_id_pad_s;
        assign unused_id_pad_s = ^up_q.id[MAX_ID_W-1:ID_W];
    end

    // Round-robin search: first pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        found_s = 1'b0;
        gidx_s  = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (!found_s && full_s[i] && (ID_W'(i) >= ptr_q)) begin
                found_s = 1'b1;
                gidx_s  = ID_W'(i);
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (!found_s && full_s[i]) begin
                found_s = 1'b1;
                gidx_s  = ID_W'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign fire_s = up_valid_q && up_ready_i;
    assign load_s = found_s && (!up_valid_q || up_ready_i);

    // Grant decode and payload select for the winning slot.
    always_comb begin
        grant_s    = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            grant_s[i] = load_s && (gidx_s == ID_W'(i));
            if (gidx_s == ID_W'(i)) begin
                sel_data_s = slot_data_s[i];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Pointer moves just past the granted child; holds when nothing is loaded.
    always_comb begin
        ptr_d = ptr_q;
        if (load_s) begin
            if (gidx_s == ID_W'(NUM_CHILDREN - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gidx_s + ID_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Output register: load a new word, or empty after a handshake with no refill.
    always_comb begin
        up_d       = up_q;
        up_valid_d = up_valid_q;
        if (load_s) begin
            up_d.data              = '0;
            up_d.data[DATA_W-1:0]  = sel_data_s;
            up_d.id                = '0;
            up_d.id[ID_W-1:0]      = gidx_s;
            up_valid_d             = 1'b1;
        end else if (fire_s) begin
            up_valid_d = 1'b0;
        end else begin
            up_valid_d = up_valid_q;
        end
    end

    // Forward counters count handshakes per source and stick at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (fire_s && (up_q.id[ID_W-1:0] == ID_W'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Node state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            up_q       <= '0;
            up_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            up_q       <= up_d;
            up_valid_q <= up_valid_d;
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign up_valid_o = up_valid_q;
    assign up_data_o  = up_q.data[DATA_W-1:0];
    assign up_id_o    = up_q.id[ID_W-1:0];
    assign busy_o     = (|full_s) || up_valid_q;

endmodule

// File: tb/tb_hier_node_agg.sv
// Directed bench for hier_node_agg: expected up-port words are queued as
// stimulus is issued and a negedge monitor pops and compares each handshake.
// A second instance with 2-bit counters covers counter saturation.
module tb_hier_node_agg;

    localparam int N  = 5;
    localparam int DW = 16;
    localparam int CW = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    child_valid, child_ready;
    logic [N*DW-1:0] child_data;
    logic            up_valid, up_ready;
    logic [DW-1:0]   up_data;
    logic [IW-1:0]   up_id;
    logic [N*CW-1:0] fwd_cnt;
    logic            busy;

    logic [N-1:0]    s_valid, s_ready;
    logic [N*DW-1:0] s_data;
    logic            s_up_valid, s_up_ready;
    logic [DW-1:0]   s_up_data;
    logic [IW-1:0]   s_up_id;
    logic [N*2-1:0]  s_fwd;
    logic            s_busy;

    exp_t exp_q[$];
    int   exp_cnt[N];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hier_node_agg #(.NUM_CHILDREN(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .child_valid_i(child_valid), .child_ready_o(child_ready), .child_data_i(child_data),
        .up_valid_o(up_valid), .up_ready_i(up_ready), .up_data_o(up_data), .up_id_o(up_id),
        .fwd_cnt_o(fwd_cnt), .busy_o(busy)
    );

    hier_node_agg #(.NUM_CHILDREN(N), .DATA_W(DW), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n),
        .child_valid_i(s_valid), .child_ready_o(s_ready), .child_data_i(s_data),
        .up_valid_o(s_up_valid), .up_ready_i(s_up_ready), .up_data_o(s_up_data), .up_id_o(s_up_id),
        .fwd_cnt_o(s_fwd), .busy_o(s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d);
        child_data[i*DW +: DW] = d;
    endtask

    task automatic push(input int id, input logic [DW-1:0] d);
        exp_t e;
        e.id   = IW'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic [N*CW-1:0] cnt_model();
        logic [N*CW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(exp_cnt[i]);
        return r;
    endfunction

    // Monitor: a handshake seen at negedge completes on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && up_valid === 1'b1 && up_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got id=%0d data=%h, no word expected", up_id, up_data);
            end else begin
                e = exp_q.pop_front();
                exp_cnt[e.id]++;
                if (up_id !== e.id || up_data !== e.data) begin
                    n_err++;
                    $display("FAIL sb_word: got id=%0d data=%h, expected id=%0d data=%h",
                             up_id, up_data, e.id, e.data);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        child_valid = '1;
        up_ready    = 1'b1;
        s_valid     = '0;
        s_data      = '0;
        s_up_ready  = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_cnt[i] = 0;
            set_data(i, 16'(32'h1000 + i));
        end

        // Reset held with every child valid.
        repeat (3) tick();
        chk("rst_child_ready", 64'(child_ready), 64'd0);
        chk("rst_up_valid", 64'(up_valid), 64'd0);
        chk("rst_fwd_cnt", 64'(fwd_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sat_fwd", 64'(s_fwd), 64'd0);

        rst_n = 1'b1;
        for (int i = 0; i < N; i++) push(i, 16'(32'h1000 + i));
        tick();
        child_valid = '0;
        chk("rel_edge1_up_valid", 64'(up_valid), 64'd0);
        chk("rel_edge1_busy", 64'(busy), 64'd1);
        tick();
        chk("rel_edge2_up", 64'({up_valid, up_id, up_data}), 64'({1'b1, 3'd0, 16'h1000}));
        repeat (6) tick();
        chk("rel_drained_busy", 64'(busy), 64'd0);
        chk("rel_fwd_cnt", 64'(fwd_cnt), 64'({5{8'd1}}));

        // Fairness: all children valid for ten edges, one word out per cycle.
        for (int i = 0; i < N; i++) set_data(i, 16'(32'h2000 + i));
        for (int k = 0; k < 14; k++) push(k % N, 16'(32'h2000 + (k % N)));
        child_valid = '1;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (c == 9) child_valid = '0;
            if (c >= 1 && c <= 14) chk("fair_streaming", 64'(up_valid), 64'd1);
            if (c == 6) chk("fair_cnt_round1", 64'(fwd_cnt), 64'({5{8'd2}}));
            if (c == 11) chk("fair_cnt_round2", 64'(fwd_cnt), 64'({5{8'd3}}));
        end
        chk("fair_busy_idle", 64'(busy), 64'd0);
        chk("fair_fwd_cnt", 64'(fwd_cnt), 64'({8'd3, 8'd4, 8'd4, 8'd4, 8'd4}));

        // Backpressure: children 1 and 4 valid while the parent stalls.
        up_ready = 1'b0;
        set_data(1, 16'h0111);
        set_data(4, 16'h0444);
        child_valid = 5'b10010;
        push(4, 16'h0444);
        push(1, 16'h0111);
        push(4, 16'h0455);
        tick();
        chk("bp_ready_b0", 64'(child_ready & 5'b10010), 64'(5'b10000));
        set_data(1, 16'h0122);
        set_data(4, 16'h0455);
        tick();
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold", 64'({up_valid, up_id, up_data, child_ready[1], child_ready[4]}),
                64'({1'b1, 3'd4, 16'h0444, 1'b0, 1'b0}));
            tick();
        end
        child_valid = '0;
        up_ready    = 1'b1;
        repeat (4) tick();
        chk("bp_drained_busy", 64'(busy), 64'd0);

        // Single word from child 3.
        set_data(3, 16'h00A5);
        child_valid = 5'b01000;
        push(3, 16'h00A5);
        tick();
        child_valid = '0;
        chk("single_edge1", 64'({up_valid, busy}), 64'(2'b01));
        tick();
        chk("single_up", 64'({up_valid, up_id, up_data}), 64'({1'b1, 3'd3, 16'h00A5}));
        tick();
        chk("single_cnt3", 64'(fwd_cnt[3*CW +: CW]), 64'd5);
        chk("single_busy", 64'(busy), 64'd0);

        // Wrap: pointer sits at 4, children 0 and 4 request; child 0 refills on drain.
        set_data(0, 16'h0A00);
        set_data(4, 16'h0B04);
        child_valid = 5'b10001;
        push(4, 16'h0B04);
        push(0, 16'h0A00);
        push(0, 16'h0A01);
        tick();
        chk("wrap_ready_w0", 64'({child_ready[4], child_ready[0]}), 64'(2'b10));
        child_valid = 5'b00001;
        set_data(0, 16'h0A01);
        tick();
        chk("wrap_first", 64'({up_valid, up_id, up_data}), 64'({1'b1, 3'd4, 16'h0B04}));
        tick();
        child_valid = '0;
        chk("wrap_second", 64'({up_valid, up_id, up_data, busy}), 64'({1'b1, 3'd0, 16'h0A00, 1'b1}));
        tick();
        chk("wrap_no_bubble", 64'({up_valid, up_id, up_data}), 64'({1'b1, 3'd0, 16'h0A01}));
        repeat (2) tick();

        // Pointer now at 1: children 0 and 1 together must grant 1 first.
        set_data(0, 16'h0C00);
        set_data(1, 16'h0C01);
        child_valid = 5'b00011;
        push(1, 16'h0C01);
        push(0, 16'h0C00);
        tick();
        child_valid = '0;
        tick();
        chk("ptr_first_id", 64'(up_id), 64'd1);
        tick();
        chk("ptr_second_id", 64'(up_id), 64'd0);
        repeat (2) tick();
        chk("cnt_model", 64'(fwd_cnt), 64'(cnt_model()));
        chk("cnt_const", 64'(fwd_cnt), 64'({8'd6, 8'd5, 8'd4, 8'd6, 8'd7}));

        // Reset with a stalled word and a full slot: both must vanish.
        up_ready = 1'b0;
        set_data(0, 16'h0D00);
        set_data(2, 16'h0D02);
        child_valid = 5'b00101;
        tick();
        child_valid = '0;
        tick();
        chk("mid_pre_busy", 64'({busy, up_valid}), 64'(2'b11));
        rst_n = 1'b0;
        repeat (2) tick();
        chk("mid_rst_state", 64'({up_valid, busy, child_ready}), 64'd0);
        chk("mid_rst_cnt", 64'(fwd_cnt), 64'd0);
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        rst_n    = 1'b1;
        up_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid_no_stale", 64'(up_valid), 64'd0);
        end

        // Saturation: 2-bit counters, child 2 forwards five words.
        s_data[2*DW +: DW] = 16'h5A5A;
        s_valid = 5'b00100;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 1) chk("sat_up", 64'({s_up_valid, s_up_id, s_up_data}), 64'({1'b1, 3'd2, 16'h5A5A}));
            if (c == 3) chk("sat_pre", 64'(s_fwd[4 +: 2]), 64'd2);
        end
        s_valid = '0;
        repeat (4) tick();
        chk("sat_cnt", 64'(s_fwd), 64'(10'b00_00_11_00_00));
        chk("sat_idle", 64'({s_up_valid, s_busy, s_ready}), 64'(7'b00_11111));

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
